// File: rtl/sram_pkg.sv
// Shared definitions for the latency-modelled SRAM: FSM state encoding and
// width helpers used by the top level and the storage array.
package sram_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_BUSY = 2'd1;
  localparam logic [1:0] ST_WR_BUSY = 2'd2;

  // Ceiling log2, never smaller than 1 so a counter or index always has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Number of byte lanes in a data word.
  function automatic int calc_be_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_be_array.sv
// Storage array with a byte-enable write port and a read port that is both
// available combinationally and registered at the request edge.
module sram_be_array
  import sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_wr_en,
  input  logic [calc_be_w(DATA_W)-1:0]  i_be,
  input  logic [clog2(DEPTH)-1:0]       i_idx,
  input  logic [DATA_W-1:0]             i_wdata,
  input  logic                          i_rd_en,
  input  logic                          i_rd_hit,
  output logic [DATA_W-1:0]             o_rd_word,
  output logic [DATA_W-1:0]             o_rd_data
);

  localparam int BE_W = calc_be_w(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Byte-lane write; contents survive reset on purpose.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Unregistered read word, zero for addresses beyond the implemented depth.
  always_comb begin
    if (i_rd_hit) begin
      o_rd_word = r_mem[i_idx];
    end else begin
      o_rd_word = '0;
    end
  end

  // Capture the read word at the acceptance edge for multi-cycle responses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= o_rd_word;
    end else begin
      r_rd_data <= r_rd_data;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sram_lat_model.sv
// Single-port SRAM model with valid/ready requests, byte-enable writes,
// programmable read/write latency and out-of-range error reporting.
module sram_lat_model
  import sram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 17,
  parameter int DEPTH     = 512,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         REQ_VALID,
  output logic                         REQ_READY,
  input  logic                         REQ_WE,
  input  logic [calc_be_w(DATA_W)-1:0] REQ_BE,
  input  logic [ADDR_W-1:0]            REQ_ADDR,
  input  logic [DATA_W-1:0]            REQ_WDATA,
  output logic                         RD_VALID,
  output logic [DATA_W-1:0]            RD_DATA,
  output logic                         WR_DONE,
  output logic                         ERR
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = clog2(MAX_LAT);
  localparam int IDX_W   = clog2(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  RD_LOAD   = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0]  WR_LOAD   = CNT_W'(WRITE_LAT - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic              RD_MULTI  = (READ_LAT > 1) ? 1'b1 : 1'b0;
  localparam logic              WR_MULTI  = (WRITE_LAT > 1) ? 1'b1 : 1'b0;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ready;
  logic              r_err_flag;
  logic              r_rd_valid;
  logic              r_wr_done;
  logic              r_err;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_accept;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;
  logic              w_cnt_last;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic              w_err_src;
  logic [DATA_W-1:0] w_rd_data_nxt;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_rd_reg;

  assign w_accept   = REQ_VALID & r_ready;
  assign w_rd_acc   = w_accept & ~REQ_WE;
  assign w_wr_acc   = w_accept & REQ_WE;
  assign w_hit      = ({1'b0, REQ_ADDR} < DEPTH_EXT);
  assign w_idx      = REQ_ADDR[IDX_W-1:0];
  assign w_cnt_last = (r_cnt == CNT_ONE);

  sram_be_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_wr_en   (w_wr_acc & w_hit),
    .i_be      (REQ_BE),
    .i_idx     (w_idx),
    .i_wdata   (REQ_WDATA),
    .i_rd_en   (w_rd_acc),
    .i_rd_hit  (w_hit),
    .o_rd_word (w_rd_word),
    .o_rd_data (w_rd_reg)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave IDLE only for multi-cycle latencies, return when the count expires.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_acc && RD_MULTI) begin
          w_state_nxt = ST_RD_BUSY;
        end else if (w_wr_acc && WR_MULTI) begin
          w_state_nxt = ST_WR_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_BUSY: begin
        if (w_cnt_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RD_BUSY;
        end
      end
      ST_WR_BUSY: begin
        if (w_cnt_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WR_BUSY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Response decode: single-cycle latencies answer straight from IDLE using live request info.
  always_comb begin
    w_rd_fire = 1'b0;
    w_wr_fire = 1'b0;
    w_err_src = r_err_flag;
    case (r_state)
      ST_IDLE: begin
        w_rd_fire = w_rd_acc & ~RD_MULTI;
        w_wr_fire = w_wr_acc & ~WR_MULTI;
        w_err_src = ~w_hit;
      end
      ST_RD_BUSY: w_rd_fire = w_cnt_last;
      ST_WR_BUSY: w_wr_fire = w_cnt_last;
      default: begin
        w_rd_fire = 1'b0;
        w_wr_fire = 1'b0;
      end
    endcase
    if (w_rd_fire) begin
      w_rd_data_nxt = RD_MULTI ? w_rd_reg : w_rd_word;
    end else begin
      w_rd_data_nxt = r_rd_data;
    end
  end

  // Latency counter: loaded at acceptance, counts down while busy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (w_rd_acc) begin
      r_cnt <= RD_LOAD;
    end else if (w_wr_acc) begin
      r_cnt <= WR_LOAD;
    end else if ((r_state != ST_IDLE) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Remember whether the accepted address was out of range until the response.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_err_flag <= 1'b0;
    end else if (w_accept) begin
      r_err_flag <= ~w_hit;
    end else begin
      r_err_flag <= r_err_flag;
    end
  end

  // Registered handshake and response outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ready    <= 1'b1;
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
      r_err      <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_ready    <= (w_state_nxt == ST_IDLE);
      r_rd_valid <= w_rd_fire;
      r_wr_done  <= w_wr_fire;
      r_err      <= (w_rd_fire | w_wr_fire) & w_err_src;
      r_rd_data  <= w_rd_data_nxt;
    end
  end

  assign REQ_READY = r_ready;
  assign RD_VALID  = r_rd_valid;
  assign WR_DONE   = r_wr_done;
  assign ERR       = r_err;
  assign RD_DATA   = r_rd_data;

endmodule

// File: tb/tb_sram_lat_model.sv
// Randomised self-checking bench: three instances with different latencies
// checked against an array-based reference of the memory and response timing.
module tb_sram_lat_model;

  localparam int NI = 3;

  function automatic int rl_of(input int k);
    case (k)
      0: return 1;
      1: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int wl_of(input int k);
    case (k)
      0: return 1;
      1: return 1;
      default: return 3;
    endcase
  endfunction

  logic        clk;
  logic        rst;
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [3:0]  req_be    [NI];
  logic [16:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        rd_valid  [NI];
  logic [31:0] rd_data   [NI];
  logic        wr_done   [NI];
  logic        err       [NI];

  logic [31:0] ref_mem [NI][512];
  logic [31:0] last_rd [NI];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_lat_model #(
      .DATA_W    (32),
      .ADDR_W    (17),
      .DEPTH     (512),
      .READ_LAT  (rl_of(g)),
      .WRITE_LAT (wl_of(g))
    ) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .REQ_VALID (req_valid[g]),
      .REQ_READY (req_ready[g]),
      .REQ_WE    (req_we[g]),
      .REQ_BE    (req_be[g]),
      .REQ_ADDR  (req_addr[g]),
      .REQ_WDATA (req_wdata[g]),
      .RD_VALID  (rd_valid[g]),
      .RD_DATA   (rd_data[g]),
      .WR_DONE   (wr_done[g]),
      .ERR       (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One request on instance k, starting and ending at a negedge with the instance idle.
  task automatic do_txn(input int k, input bit we, input logic [3:0] be,
                        input logic [16:0] addr, input logic [31:0] wd,
                        input int hold, output logic [31:0] got);
    int lat;
    int n;
    bit oor;
    logic [31:0] exp_d;
    lat = we ? wl_of(k) : rl_of(k);
    oor = (addr >= 17'd512);
    got = '0;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_be[k]    = be;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_eq("accept_timeout", 32'(n < 20), 32'd1);
    if (we && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_mem[k][addr[8:0]][8*b +: 8] = wd[8*b +: 8];
      end
    end
    exp_d = oor ? 32'd0 : ref_mem[k][addr[8:0]];
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      chk_eq("ready", 32'(req_ready[k]), 32'(c >= lat));
      chk_eq(we ? "wr_done" : "rd_valid", 32'(we ? wr_done[k] : rd_valid[k]), 32'(c == lat));
      chk_eq(we ? "rd_valid_on_wr" : "wr_done_on_rd", 32'(we ? rd_valid[k] : wr_done[k]), 32'd0);
      chk_eq("err", 32'(err[k]), 32'(c == lat && oor));
      if (c == lat) begin
        if (!we) begin
          chk_eq("rd_data", rd_data[k], exp_d);
          last_rd[k] = exp_d;
        end else begin
          chk_eq("rd_data_hold", rd_data[k], last_rd[k]);
        end
        got = rd_data[k];
      end
      if (c > hold) req_valid[k] = 1'b0;
    end
  endtask

  logic [31:0] got;
  logic [31:0] save88;
  logic [16:0] a;
  int          lat_r;

  initial begin
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_be[k]    = 4'h0;
      req_addr[k]  = 17'd0;
      req_wdata[k] = 32'd0;
      last_rd[k]   = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk_eq("rst_rd_valid", 32'(rd_valid[k]), 32'd0);
      chk_eq("rst_wr_done", 32'(wr_done[k]), 32'd0);
      chk_eq("rst_err", 32'(err[k]), 32'd0);
      chk_eq("rst_rd_data", rd_data[k], 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk_eq("rst_ready", 32'(req_ready[k]), 32'd1);

    // Fill the address pool used by random traffic so every read has a known value.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 34; i++) begin
        a = (i < 32) ? 17'(i) : ((i == 32) ? 17'd88 : 17'd511);
        do_txn(k, 1'b1, 4'hF, a, $urandom, 0, got);
      end
    end

    // Directed: full write then read with READ_LAT=2 / WRITE_LAT=1.
    do_txn(1, 1'b1, 4'hF, 17'd5, 32'hDEADBEEF, 0, got);
    do_txn(1, 1'b0, 4'h0, 17'd5, 32'd0, 0, got);
    chk_eq("dir_deadbeef", got, 32'hDEADBEEF);

    // Directed: partial byte-enable write merge, then an all-zero enable write.
    do_txn(1, 1'b1, 4'hF, 17'd7, 32'h11223344, 0, got);
    do_txn(1, 1'b1, 4'b0101, 17'd7, 32'hAABBCCDD, 0, got);
    do_txn(1, 1'b0, 4'h0, 17'd7, 32'd0, 0, got);
    chk_eq("dir_be_merge", got, 32'h11BB33DD);
    do_txn(1, 1'b1, 4'h0, 17'd7, 32'h55667788, 0, got);
    do_txn(1, 1'b0, 4'h0, 17'd7, 32'd0, 0, got);
    chk_eq("dir_be_zero", got, 32'h11BB33DD);

    // Directed: out-of-range read/write and the depth boundary.
    do_txn(1, 1'b0, 4'h0, 17'd600, 32'd0, 0, got);
    chk_eq("dir_oor_rd_data", got, 32'd0);
    save88 = ref_mem[1][88];
    do_txn(1, 1'b1, 4'hF, 17'd600, 32'hCAFEF00D, 0, got);
    do_txn(1, 1'b0, 4'h0, 17'd88, 32'd0, 0, got);
    chk_eq("dir_alias_88", got, save88);
    do_txn(1, 1'b0, 4'h0, 17'd512, 32'd0, 0, got);
    do_txn(1, 1'b0, 4'h0, 17'd511, 32'd0, 0, got);
    do_txn(1, 1'b0, 4'h0, 17'h1FFFF, 32'd0, 0, got);

    // Directed: back-to-back reads at READ_LAT=1 with REQ_VALID held.
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 17'd0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk_eq("tput_ready", 32'(req_ready[0]), 32'd1);
      chk_eq("tput_rd_valid", 32'(rd_valid[0]), 32'd1);
      chk_eq("tput_rd_data", rd_data[0], ref_mem[0][i-1]);
      if (i < 4) req_addr[0] = 17'(i);
      else req_valid[0] = 1'b0;
    end
    @(negedge clk);
    chk_eq("tput_end", 32'(rd_valid[0]), 32'd0);
    last_rd[0] = ref_mem[0][3];

    // Directed: request held while busy at READ_LAT=4 is accepted once.
    do_txn(2, 1'b0, 4'h0, 17'd3, 32'd0, 2, got);

    // Directed: reset two cycles into a READ_LAT=4 read abandons it.
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = 17'd9;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("rstmid_rd_valid", 32'(rd_valid[2]), 32'd0);
    chk_eq("rstmid_rd_data", rd_data[2], 32'd0);
    rst = 1'b1;
    for (int k = 0; k < NI; k++) last_rd[k] = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_eq("rstmid_no_pulse", 32'(rd_valid[2]), 32'd0);
      chk_eq("rstmid_ready", 32'(req_ready[2]), 32'd1);
    end
    do_txn(2, 1'b0, 4'h0, 17'd9, 32'd0, 0, got);

    // Random traffic against the reference model.
    for (int k = 0; k < NI; k++) begin
      for (int t = 0; t < 40; t++) begin
        int r;
        bit we;
        r = $urandom_range(0, 9);
        if (r < 7)       a = 17'($urandom_range(0, 31));
        else if (r == 7) a = 17'd88;
        else if (r == 8) a = 17'd511;
        else             a = 17'($urandom_range(512, 131071));
        we = 1'($urandom_range(0, 1));
        lat_r = we ? wl_of(k) : rl_of(k);
        do_txn(k, we, 4'($urandom), a, $urandom, $urandom_range(0, lat_r - 1), got);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
